multicycle_control: RTL and testbench



---
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle for the multicycle controller: instruction fields
// and ALU flag in, select lines, write strobes and debug state out.
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  // Datapath side: supplies IR fields and the zero flag, consumes controls.
  modport master (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal, state
  );

  // Controller side.
  modport slave (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM sequencing a shared ALU/memory/result-mux datapath over
// several cycles per instruction (lw, sw, R-type, I-type ALU, beq, jal).
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  state_t     state_q, state_d;

  logic       pc_update;
  logic       branch;
  logic       adr_src;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       done_raw;
  logic       illegal_op;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] alu_control;
  logic [1:0] imm_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    done_raw      = 1'b0;
    illegal_op    = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        // Branch target OldPC + imm is precomputed here for BEQ.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal_op = 1'b1;
            done_raw   = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_FN;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FN;
        state_d   = S_ALUWB;
      end
      S_JAL: begin
        // OldPC + 4 is the link value; PC takes the target from ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        done_raw  = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      ALUOP_SUB: alu_control = 3'b001;
      ALUOP_FN: begin
        case (bus.funct3)
          // Only R-type with instr[30] set means sub; addi ignores funct7b5.
          3'b000:  alu_control = ({bus.op[5], bus.funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Strobes are gated by rst_n so nothing fires while reset is held.
  assign bus.PCWrite    = rst_n & (pc_update | (branch & bus.zero));
  assign bus.IRWrite    = rst_n & ir_write_raw;
  assign bus.RegWrite   = rst_n & reg_write_raw;
  assign bus.MemWrite   = rst_n & mem_write_raw;
  assign bus.instr_done = rst_n & done_raw;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = imm_src;
  assign bus.illegal    = illegal_op;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle and checks every control output against hand-written expectations.
module tb_multicycle_control;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  multicycle_control_if cif ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_cyc(input string tag, input logic [3:0] st,
                         input logic pcw, input logic adr, input logic mw,
                         input logic irw, input logic rw,
                         input logic [1:0] rs, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [2:0] aluc,
                         input logic [1:0] imm, input logic done,
                         input logic ill);
    #1;
    chk({tag, ".state"},      {4'b0, cif.state},      {4'b0, st});
    chk({tag, ".PCWrite"},    {7'b0, cif.PCWrite},    {7'b0, pcw});
    chk({tag, ".AdrSrc"},     {7'b0, cif.AdrSrc},     {7'b0, adr});
    chk({tag, ".MemWrite"},   {7'b0, cif.MemWrite},   {7'b0, mw});
    chk({tag, ".IRWrite"},    {7'b0, cif.IRWrite},    {7'b0, irw});
    chk({tag, ".RegWrite"},   {7'b0, cif.RegWrite},   {7'b0, rw});
    chk({tag, ".ResultSrc"},  {6'b0, cif.ResultSrc},  {6'b0, rs});
    chk({tag, ".ALUSrcA"},    {6'b0, cif.ALUSrcA},    {6'b0, sa});
    chk({tag, ".ALUSrcB"},    {6'b0, cif.ALUSrcB},    {6'b0, sb});
    chk({tag, ".ALUControl"}, {5'b0, cif.ALUControl}, {5'b0, aluc});
    chk({tag, ".ImmSrc"},     {6'b0, cif.ImmSrc},     {6'b0, imm});
    chk({tag, ".instr_done"}, {7'b0, cif.instr_done}, {7'b0, done});
    chk({tag, ".illegal"},    {7'b0, cif.illegal},    {7'b0, ill});
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    cif.op       = op;
    cif.funct3   = f3;
    cif.funct7b5 = f7;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    cif.zero = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0);

    // Reset held for 3 cycles: FETCH selects visible, strobes masked.
    repeat (3) @(posedge clk);
    exp_cyc("rst_hold", 4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10,3'b000, 2'b00, 0,0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cyc("rst_rel_fetch", 4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,3'b000, 2'b00, 0,0);

    // lw: 0,1,2,3,4
    tick(); exp_cyc("lw_decode",  4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("lw_memadr",  4'd2, 0,0,0,0,0, 2'b00,2'b10,2'b01,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("lw_memread", 4'd3, 0,1,0,0,0, 2'b00,2'b00,2'b00,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("lw_memwb",   4'd4, 0,0,0,0,1, 2'b01,2'b00,2'b00,3'b000, 2'b00, 1,0);

    // sw: 0,1,2,5
    tick(); set_instr(7'b0100011, 3'b010, 1'b0);
    exp_cyc("sw_fetch",    4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,3'b000, 2'b01, 0,0);
    tick(); exp_cyc("sw_decode",   4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000, 2'b01, 0,0);
    tick(); exp_cyc("sw_memadr",   4'd2, 0,0,0,0,0, 2'b00,2'b10,2'b01,3'b000, 2'b01, 0,0);
    tick(); exp_cyc("sw_memwrite", 4'd5, 0,1,1,0,0, 2'b00,2'b00,2'b00,3'b000, 2'b01, 1,0);

    // R-type sub: 0,1,6,7
    tick(); set_instr(7'b0110011, 3'b000, 1'b1);
    exp_cyc("sub_fetch",  4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("sub_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("sub_execr",  4'd6, 0,0,0,0,0, 2'b00,2'b10,2'b00,3'b001, 2'b00, 0,0);
    tick(); exp_cyc("sub_aluwb",  4'd7, 0,0,0,0,1, 2'b00,2'b00,2'b00,3'b000, 2'b00, 1,0);

    // R-type slt
    tick(); set_instr(7'b0110011, 3'b010, 1'b0);
    exp_cyc("slt_fetch",  4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("slt_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("slt_execr",  4'd6, 0,0,0,0,0, 2'b00,2'b10,2'b00,3'b101, 2'b00, 0,0);
    tick(); exp_cyc("slt_aluwb",  4'd7, 0,0,0,0,1, 2'b00,2'b00,2'b00,3'b000, 2'b00, 1,0);

    // beq taken (zero = 1): 0,1,10
    tick(); set_instr(7'b1100011, 3'b000, 1'b0); cif.zero = 1'b1;
    exp_cyc("beq1_fetch",  4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,3'b000, 2'b10, 0,0);
    tick(); exp_cyc("beq1_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000, 2'b10, 0,0);
    tick(); exp_cyc("beq1_beq",    4'd10, 1,0,0,0,0, 2'b00,2'b10,2'b00,3'b001, 2'b10, 1,0);

    // beq not taken (zero = 0)
    tick(); cif.zero = 1'b0;
    exp_cyc("beq0_fetch",  4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,3'b000, 2'b10, 0,0);
    tick(); exp_cyc("beq0_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000, 2'b10, 0,0);
    tick(); exp_cyc("beq0_beq",    4'd10, 0,0,0,0,0, 2'b00,2'b10,2'b00,3'b001, 2'b10, 1,0);

    // jal: 0,1,9,7
    tick(); set_instr(7'b1101111, 3'b000, 1'b0);
    exp_cyc("jal_fetch",  4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,3'b000, 2'b11, 0,0);
    tick(); exp_cyc("jal_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000, 2'b11, 0,0);
    tick(); exp_cyc("jal_jal",    4'd9, 1,0,0,0,0, 2'b00,2'b01,2'b10,3'b000, 2'b11, 0,0);
    tick(); exp_cyc("jal_aluwb",  4'd7, 0,0,0,0,1, 2'b00,2'b00,2'b00,3'b000, 2'b11, 1,0);

    // ori: 0,1,8,7
    tick(); set_instr(7'b0010011, 3'b110, 1'b0);
    exp_cyc("ori_fetch",  4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("ori_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("ori_execi",  4'd8, 0,0,0,0,0, 2'b00,2'b10,2'b01,3'b011, 2'b00, 0,0);
    tick(); exp_cyc("ori_aluwb",  4'd7, 0,0,0,0,1, 2'b00,2'b00,2'b00,3'b000, 2'b00, 1,0);

    // addi with instr[30] set must still add; andi checks the and code
    tick(); set_instr(7'b0010011, 3'b000, 1'b1);
    exp_cyc("addi_fetch", 4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("addi_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("addi_execi",  4'd8, 0,0,0,0,0, 2'b00,2'b10,2'b01,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("addi_aluwb",  4'd7, 0,0,0,0,1, 2'b00,2'b00,2'b00,3'b000, 2'b00, 1,0);
    tick(); set_instr(7'b0010011, 3'b111, 1'b0);
    exp_cyc("andi_fetch", 4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("andi_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("andi_execi",  4'd8, 0,0,0,0,0, 2'b00,2'b10,2'b01,3'b010, 2'b00, 0,0);
    tick(); exp_cyc("andi_aluwb",  4'd7, 0,0,0,0,1, 2'b00,2'b00,2'b00,3'b000, 2'b00, 1,0);

    // Illegal opcode: 0,1 then straight back to FETCH
    tick(); set_instr(7'b1111111, 3'b000, 1'b0);
    exp_cyc("ill_fetch",  4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,3'b000, 2'b00, 0,0);
    tick(); exp_cyc("ill_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000, 2'b00, 1,1);
    tick(); set_instr(7'b0100011, 3'b010, 1'b0);
    exp_cyc("ill_next_fetch", 4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,3'b000, 2'b01, 0,0);

    // sw aborted by reset while in MEMADR
    tick(); exp_cyc("abort_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000, 2'b01, 0,0);
    tick(); exp_cyc("abort_memadr", 4'd2, 0,0,0,0,0, 2'b00,2'b10,2'b01,3'b000, 2'b01, 0,0);
    rst_n = 1'b0;
    exp_cyc("abort_rst_now",  4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10,3'b000, 2'b01, 0,0);
    tick(); exp_cyc("abort_rst_edge", 4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10,3'b000, 2'b01, 0,0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cyc("abort_rel_fetch", 4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,3'b000, 2'b01, 0,0);
    tick(); exp_cyc("abort_redecode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000, 2'b01, 0,0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
